aes_sequencer: RTL and testbench

AES_SEQUENCER -- requirements
Module: aes_sequencer

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_sequencer_if.sv | 40 ++++
 rtl/aes_mode_mux.sv | 57 +++++
 rtl/aes_sequencer.sv | 160 ++++++++++++++++
 tb/tb_aes_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES block-mode sequencer: FSM states,
// mode codes, command-word bit positions and the registered output bundle.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_KEYEXP,
    ST_LOAD,
    ST_WAIT,
    ST_WB_OUT,
    ST_WB_AUX,
    ST_DONE
  } state_e;

  localparam logic [2:0] MODE_KEY = 3'b000;
  localparam logic [2:0] MODE_ECB = 3'b001;
  localparam logic [2:0] MODE_CBC = 3'b010;
  localparam logic [2:0] MODE_CTR = 3'b101;

  localparam int CMD_START_BIT    = 31;
  localparam int CMD_CTR_ZERO_BIT = 4;
  localparam int CMD_DIR_BIT      = 3;
  localparam int CMD_MODE_MSB     = 2;
  localparam int CMD_MODE_LSB     = 0;

  localparam logic [1:0] DEST_R0 = 2'b00;
  localparam logic [1:0] DEST_R1 = 2'b01;
  localparam logic [1:0] DEST_R2 = 2'b10;
  localparam logic [1:0] DEST_R3 = 2'b11;

  typedef struct packed {
    logic         enable_amba;
    logic         wr_control;
    logic [1:0]   reg_dest;
    logic [127:0] bus_r;
    logic         expanding;
    logic         ks_start;
    logic         core_start;
    logic         core_decrypt;
    logic [127:0] core_in;
    logic         busy;
    logic         err;
  } out_t;

  function automatic logic mode_reserved(input logic [2:0] mode);
    return !(mode inside {MODE_KEY, MODE_ECB, MODE_CBC, MODE_CTR});
  endfunction

endpackage

// File: rtl/aes_sequencer_if.sv
// Register-file, key-schedule and cipher-core signals seen by the sequencer.
// master = sequencer side, slave = register file / key schedule / core side.
interface aes_sequencer_if;

  logic [31:0]  reg_command;
  logic         key_ready;
  logic [127:0] key;
  logic [127:0] r0;
  logic [127:0] r1;
  logic [63:0]  r3;

  logic         enable_amba;
  logic         wr_control;
  logic [1:0]   reg_dest;
  logic [127:0] busR;
  logic         expanding;

  logic         ks_start;
  logic         ks_done;
  logic         core_start;
  logic         core_decrypt;
  logic [127:0] core_in;
  logic         core_done;
  logic [127:0] core_result;
  logic         busy;
  logic         err;

  modport master (
    input  reg_command, key_ready, key, r0, r1, r3, ks_done, core_done, core_result,
    output enable_amba, wr_control, reg_dest, busR, expanding,
           ks_start, core_start, core_decrypt, core_in, busy, err
  );

  modport slave (
    output reg_command, key_ready, key, r0, r1, r3, ks_done, core_done, core_result,
    input  enable_amba, wr_control, reg_dest, busR, expanding,
           ks_start, core_start, core_decrypt, core_in, busy, err
  );

endinterface

// File: rtl/aes_mode_mux.sv
// Per-mode data selection: cipher-core input in LOAD, write-back bus value and
// destination in WB_OUT / WB_AUX. All outputs are zero in every other state.
module aes_mode_mux
  import aes_pkg::*;
(
  input  state_e       state_i,
  input  logic [2:0]   mode_i,
  input  logic         decrypt_i,
  input  logic [127:0] r0_i,
  input  logic [127:0] r1_i,
  input  logic [63:0]  r3_i,
  input  logic [127:0] result_i,
  output logic [127:0] core_in_o,
  output logic         core_decrypt_o,
  output logic [127:0] bus_r_o,
  output logic [1:0]   reg_dest_o
);

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    core_in_o      = '0;
    core_decrypt_o = 1'b0;
    bus_r_o        = '0;
    reg_dest_o     = DEST_R0;
    case (state_i)
      ST_LOAD: begin
        core_decrypt_o = (mode_i == MODE_CTR) ? 1'b0 : decrypt_i;
        case (mode_i)
          MODE_CBC: core_in_o = decrypt_i ? r0_i : (r0_i ^ r1_i);
          MODE_CTR: core_in_o = {r1_i[127:64], r3_i};
          default:  core_in_o = r0_i;
        endcase
      end
      ST_WB_OUT: begin
        reg_dest_o = DEST_R2;
        case (mode_i)
          MODE_CBC: bus_r_o = decrypt_i ? (result_i ^ r1_i) : result_i;
          MODE_CTR: bus_r_o = result_i ^ r0_i;
          default:  bus_r_o = result_i;
        endcase
      end
      ST_WB_AUX: begin
        if (mode_i == MODE_CTR) begin
          // Counter wraps modulo 2^64 by plain width truncation.
          reg_dest_o = DEST_R3;
          bus_r_o    = {64'h0, r3_i + 64'd1};
        end else begin
          reg_dest_o = DEST_R1;
          bus_r_o    = decrypt_i ? r0_i : result_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/aes_sequencer.sv
// AES block-mode sequencer: walks key expansion, core launch and register
// write-back for ECB, CBC and CTR; every output is a flop.
module aes_sequencer
  import aes_pkg::*;
(
  input  logic             ACLK,
  input  logic             ARSTn,
  aes_sequencer_if.master  bus
);

  state_e       state_q, state_d;
  logic [2:0]   mode_q, mode_d;
  logic         dir_q, dir_d;
  logic         key_valid_q, key_valid_d;
  logic         err_d;
  logic [127:0] snap_r0_q, snap_r0_d;
  logic [127:0] snap_r1_q, snap_r1_d;
  logic [63:0]  snap_r3_q, snap_r3_d;
  logic [127:0] result_q, result_d;
  out_t         out_q, out_d;

  logic [127:0] mux_core_in;
  logic         mux_core_decrypt;
  logic [127:0] mux_bus_r;
  logic [1:0]   mux_reg_dest;

  // The key and key_ready go straight to the key schedule; the register file
  // itself acts on counter-zero. Only start, direction and mode matter here.
  logic unused_inputs;
  assign unused_inputs = ^{bus.key, bus.key_ready, bus.reg_command[30:CMD_CTR_ZERO_BIT]};

  // NOTE: always_comb uses blocking '=' so later lines see earlier defaults;
  // the always_ff blocks below use non-blocking '<=' so all flops update together.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    dir_d       = dir_q;
    key_valid_d = key_valid_q;
    err_d       = 1'b0;
    result_d    = result_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.reg_command[CMD_START_BIT]) begin
          state_d = ST_SETUP;
          mode_d  = bus.reg_command[CMD_MODE_MSB:CMD_MODE_LSB];
          dir_d   = bus.reg_command[CMD_DIR_BIT];
        end
      end
      ST_SETUP: begin
        if (mode_reserved(mode_q)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (mode_q == MODE_KEY || !key_valid_q) begin
          state_d = ST_KEYEXP;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_KEYEXP: begin
        if (bus.ks_done) begin
          key_valid_d = 1'b1;
          state_d     = (mode_q == MODE_KEY) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.core_done) begin
          result_d = bus.core_result;
          state_d  = ST_WB_OUT;
        end
      end
      ST_WB_OUT: state_d = (mode_q == MODE_ECB) ? ST_DONE : ST_WB_AUX;
      ST_WB_AUX: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Operands are captured on LOAD entry so the register file may move on.
  always_comb begin
    snap_r0_d = snap_r0_q;
    snap_r1_d = snap_r1_q;
    snap_r3_d = snap_r3_q;
    if (state_d == ST_LOAD) begin
      snap_r0_d = bus.r0;
      snap_r1_d = bus.r1;
      snap_r3_d = bus.r3;
    end
  end

  // Outputs are decoded from the next state and registered, so each output
  // is valid for exactly the cycles its state is occupied.
  aes_mode_mux u_mode_mux (
    .state_i        (state_d),
    .mode_i         (mode_d),
    .decrypt_i      (dir_d),
    .r0_i           (snap_r0_d),
    .r1_i           (snap_r1_d),
    .r3_i           (snap_r3_d),
    .result_i       (result_d),
    .core_in_o      (mux_core_in),
    .core_decrypt_o (mux_core_decrypt),
    .bus_r_o        (mux_bus_r),
    .reg_dest_o     (mux_reg_dest)
  );

  always_comb begin
    out_d              = '0;
    out_d.enable_amba  = (state_d == ST_IDLE);
    out_d.wr_control   = (state_d inside {ST_WB_OUT, ST_WB_AUX});
    out_d.reg_dest     = mux_reg_dest;
    out_d.bus_r        = mux_bus_r;
    out_d.expanding    = (state_d == ST_KEYEXP);
    out_d.ks_start     = (state_d == ST_KEYEXP) && (state_q != ST_KEYEXP);
    out_d.core_start   = (state_d == ST_LOAD);
    out_d.core_decrypt = mux_core_decrypt;
    out_d.core_in      = mux_core_in;
    out_d.busy         = !(state_d inside {ST_IDLE, ST_DONE});
    out_d.err          = err_d;
  end

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q           <= ST_IDLE;
      mode_q            <= MODE_KEY;
      dir_q             <= 1'b0;
      key_valid_q       <= 1'b0;
      out_q             <= '0;
      out_q.enable_amba <= 1'b1;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
      key_valid_q <= key_valid_d;
      out_q       <= out_d;
    end
  end

  // NOTE: the wide operand/result registers are deliberately not reset; they
  // are always written (LOAD / WAIT) before any state reads them.
  always_ff @(posedge ACLK) begin
    snap_r0_q <= snap_r0_d;
    snap_r1_q <= snap_r1_d;
    snap_r3_q <= snap_r3_d;
    result_q  <= result_d;
  end

  assign bus.enable_amba  = out_q.enable_amba;
  assign bus.wr_control   = out_q.wr_control;
  assign bus.reg_dest     = out_q.reg_dest;
  assign bus.busR         = out_q.bus_r;
  assign bus.expanding    = out_q.expanding;
  assign bus.ks_start     = out_q.ks_start;
  assign bus.core_start   = out_q.core_start;
  assign bus.core_decrypt = out_q.core_decrypt;
  assign bus.core_in      = out_q.core_in;
  assign bus.busy         = out_q.busy;
  assign bus.err          = out_q.err;

endmodule

// File: tb/tb_aes_sequencer.sv
// Directed bench for aes_sequencer: the bench plays register file, key
// schedule and cipher core, using FIPS-197 / SP800-38A vectors as core results.
module tb_aes_sequencer;

  logic ACLK  = 1'b0;
  logic ARSTn = 1'b0;
  always #5 ACLK = ~ACLK;

  aes_sequencer_if bus ();

  aes_sequencer dut (
    .ACLK  (ACLK),
    .ARSTn (ARSTn),
    .bus   (bus)
  );

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CBC_IV   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CBC_P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CBC_IB1  = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] CBC_C1   = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CBC_P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CBC_IB2  = 128'hd86421fb9f1a1eda505ee1375746972c;
  localparam logic [127:0] CBC_C2   = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] CTR_E    = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
  localparam logic [127:0] CTR_CT   = 128'h874d6191b620e3261bef6864990db6ce;

  int checks = 0;
  int errors = 0;

  // Event counters, sampled at the rising edge (pre-update values).
  int n_wr = 0, n_cs = 0, n_ks = 0, n_exp = 0, n_err = 0, n_viol = 0;
  always @(posedge ACLK) begin
    if (bus.wr_control) n_wr++;
    if (bus.core_start) n_cs++;
    if (bus.ks_start) n_ks++;
    if (bus.expanding) n_exp++;
    if (bus.err) n_err++;
    if (bus.wr_control && bus.enable_amba) n_viol++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
  endtask

  // Present a command, then clear start/counter-zero during SETUP as the
  // register file would. Returns in the first cycle after SETUP.
  task automatic issue(input string tag, input logic [31:0] cmd);
    bus.reg_command = cmd;
    tick();
    check({tag, "_setup_amba"}, bus.enable_amba, 1'b0);
    check({tag, "_setup_busy"}, bus.busy, 1'b1);
    bus.reg_command = cmd & 32'h7fff_ffef;
    tick();
  endtask

  // Called in LOAD; plays the core with a one-cycle WAIT, checks both writes.
  task automatic run_data(input string tag, input logic [127:0] exp_in, input logic exp_dec,
                          input logic [127:0] res, input logic [127:0] exp_out,
                          input logic has_aux, input logic [1:0] aux_dest,
                          input logic [127:0] exp_aux);
    check({tag, "_core_start"}, bus.core_start, 1'b1);
    check({tag, "_core_in"}, bus.core_in, exp_in);
    check({tag, "_core_decrypt"}, bus.core_decrypt, exp_dec);
    tick();
    check({tag, "_wait_core_start"}, bus.core_start, 1'b0);
    check({tag, "_wait_core_in"}, bus.core_in, 128'h0);
    // Disturb live operands and command: the block must use its snapshot.
    bus.r0 = ~bus.r0;
    bus.r1 = ~bus.r1;
    bus.r3 = ~bus.r3;
    bus.reg_command = 32'h0000_000e;
    bus.core_result = res;
    bus.core_done   = 1'b1;
    tick();
    bus.core_done   = 1'b0;
    bus.core_result = '1;
    check({tag, "_out_wr"}, bus.wr_control, 1'b1);
    check({tag, "_out_dest"}, bus.reg_dest, 2'b10);
    check({tag, "_out_bus"}, bus.busR, exp_out);
    check({tag, "_out_amba"}, bus.enable_amba, 1'b0);
    tick();
    if (has_aux) begin
      check({tag, "_aux_wr"}, bus.wr_control, 1'b1);
      check({tag, "_aux_dest"}, bus.reg_dest, aux_dest);
      check({tag, "_aux_bus"}, bus.busR, exp_aux);
      tick();
    end
    check({tag, "_done_busy"}, bus.busy, 1'b0);
    check({tag, "_done_wr"}, bus.wr_control, 1'b0);
    check({tag, "_done_bus"}, bus.busR, 128'h0);
    tick();
    check({tag, "_idle_amba"}, bus.enable_amba, 1'b1);
  endtask

  initial begin
    int b_wr, b_cs, b_ks, b_exp, b_err;
    bus.reg_command = '0;
    bus.key_ready   = 1'b0;
    bus.key         = '0;
    bus.r0          = '0;
    bus.r1          = '0;
    bus.r3          = '0;
    bus.ks_done     = 1'b0;
    bus.core_done   = 1'b0;
    bus.core_result = '0;

    // Reset state.
    repeat (2) tick();
    check("rst_amba", bus.enable_amba, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_wr", bus.wr_control, 1'b0);
    check("rst_core_in", bus.core_in, 128'h0);
    check("rst_busR", bus.busR, 128'h0);
    check("rst_err", bus.err, 1'b0);
    ARSTn = 1'b1;
    tick();

    // Key expansion, ks_done after 10 cycles.
    bus.key = FIPS_KEY;
    bus.key_ready = 1'b1;
    b_wr = n_wr; b_ks = n_ks; b_exp = n_exp;
    issue("kx", 32'h8000_0000);
    check("kx_ks_start", bus.ks_start, 1'b1);
    check("kx_expanding", bus.expanding, 1'b1);
    tick();
    check("kx_ks_pulse", bus.ks_start, 1'b0);
    repeat (8) tick();
    bus.ks_done = 1'b1;
    tick();
    bus.ks_done = 1'b0;
    check("kx_done_busy", bus.busy, 1'b0);
    check("kx_done_exp", bus.expanding, 1'b0);
    check("kx_done_amba", bus.enable_amba, 1'b0);
    tick();
    check("kx_idle_amba", bus.enable_amba, 1'b1);
    check("kx_exp_cycles", n_exp - b_exp, 10);
    check("kx_ks_pulses", n_ks - b_ks, 1);
    check("kx_no_write", n_wr - b_wr, 0);

    // ECB encrypt, key already valid so no re-expansion.
    bus.r0 = FIPS_PT;
    b_ks = n_ks;
    issue("ecb", 32'h8000_0001);
    run_data("ecb", FIPS_PT, 1'b0, FIPS_CT, FIPS_CT, 1'b0, 2'b00, 128'h0);
    check("ecb_no_kx", n_ks - b_ks, 0);

    // CBC encrypt, two chained blocks.
    bus.r0 = CBC_P1;
    bus.r1 = CBC_IV;
    issue("cbc1", 32'h8000_0002);
    run_data("cbc1", CBC_IB1, 1'b0, CBC_C1, CBC_C1, 1'b1, 2'b01, CBC_C1);
    bus.r0 = CBC_P2;
    bus.r1 = CBC_C1;
    issue("cbc2", 32'h8000_0002);
    run_data("cbc2", CBC_IB2, 1'b0, CBC_C2, CBC_C2, 1'b1, 2'b01, CBC_C2);

    // CBC decrypt of block 2.
    bus.r0 = CBC_C2;
    bus.r1 = CBC_C1;
    issue("cbcd", 32'h8000_000a);
    run_data("cbcd", CBC_C2, 1'b1, CBC_IB2, CBC_P2, 1'b1, 2'b01, CBC_C2);

    // CTR with counter wrap, direction=1 and counter-zero set.
    bus.r0 = CBC_P1;
    bus.r1 = 128'hf0f1f2f3f4f5f6f7_0123456789abcdef;
    bus.r3 = 64'hffff_ffff_ffff_ffff;
    issue("ctrw", 32'h8000_001d);
    run_data("ctrw", 128'hf0f1f2f3f4f5f6f7_ffffffffffffffff, 1'b0, CTR_E, CTR_CT,
             1'b1, 2'b11, 128'h0);

    // CTR with carry across the 32-bit boundary.
    bus.r0 = '1;
    bus.r1 = 128'h0011223344556677_8899aabbccddeeff;
    bus.r3 = 64'h0000_0000_ffff_ffff;
    issue("ctr", 32'h8000_0005);
    run_data("ctr", 128'h0011223344556677_00000000ffffffff, 1'b0,
             128'h0123456789abcdef0011223344556677, 128'hfedcba9876543210ffeeddccbbaa9988,
             1'b1, 2'b11, 128'h0000000000000000_0000000100000000);

    // Reserved mode 110.
    b_wr = n_wr; b_cs = n_cs; b_ks = n_ks; b_err = n_err;
    issue("rsv", 32'h8000_0006);
    check("rsv_err", bus.err, 1'b1);
    check("rsv_amba", bus.enable_amba, 1'b1);
    check("rsv_busy", bus.busy, 1'b0);
    tick();
    check("rsv_err_pulse", bus.err, 1'b0);
    tick();
    check("rsv_err_count", n_err - b_err, 1);
    check("rsv_no_start", n_cs - b_cs, 0);
    check("rsv_no_kx", n_ks - b_ks, 0);
    check("rsv_no_write", n_wr - b_wr, 0);

    // Reset during WAIT, then a stray core_done.
    bus.r0 = FIPS_PT;
    issue("rstw", 32'h8000_0001);
    tick();
    check("rstw_wait_busy", bus.busy, 1'b1);
    b_wr = n_wr;
    ARSTn = 1'b0;
    #1;
    check("rstw_amba", bus.enable_amba, 1'b1);
    check("rstw_busy", bus.busy, 1'b0);
    tick();
    ARSTn = 1'b1;
    bus.core_result = FIPS_CT;
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    tick();
    check("rstw_no_write", n_wr - b_wr, 0);
    check("rstw_idle_busy", bus.busy, 1'b0);
    check("rstw_idle_amba", bus.enable_amba, 1'b1);

    // Next command must re-expand the key first.
    bus.r0 = FIPS_PT;
    issue("rekx", 32'h8000_0001);
    check("rekx_ks_start", bus.ks_start, 1'b1);
    check("rekx_expanding", bus.expanding, 1'b1);
    tick();
    bus.ks_done = 1'b1;
    tick();
    bus.ks_done = 1'b0;
    run_data("rekx", FIPS_PT, 1'b0, FIPS_CT, FIPS_CT, 1'b0, 2'b00, 128'h0);

    check("wr_while_amba", n_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
